// File: rtl/i2s_frame_fifo.sv
// I2S stereo frame packer: resyncs wclk, captures L/R words, and buffers
// {L,R} frames in a first-word-fall-through FIFO with a valid/ready output.
module i2s_frame_fifo #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int HOLD_DLY   = 2,
  parameter int DROP_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                i2s_wclk,
  input  logic [DATA_W-1:0]   dataL,
  input  logic [DATA_W-1:0]   dataR,
  input  logic                detectL,
  input  logic                detectR,
  output logic [2*DATA_W-1:0] frame_data,
  output logic [1:0]          frame_detect,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [ADDR_W:0]     fifo_level,
  output logic                overflow,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int FW = 2*DATA_W + 2;
  localparam logic [3:0] HOLD = 4'(HOLD_DLY);

  typedef enum logic [2:0] {
    S_SYNC, S_LDLY, S_WFALL, S_RDLY, S_WRISE
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic ws0, ws1, ws2;
  logic rise, fall;
  logic cap_l, push;
  logic [DATA_W-1:0] l_hold;
  logic dl_hold;

  assign rise = ws1 & ~ws2;
  assign fall = ~ws1 & ws2;

  // Any edge during a hold delay aborts the frame; edges win over capture.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_l     = 1'b0;
    push      = 1'b0;
    if (!enable) begin
      state_nxt = S_SYNC;
    end else begin
      unique case (state)
        S_SYNC: begin
          if (rise) begin
            state_nxt = S_LDLY;
            cnt_nxt   = HOLD;
          end
        end
        S_LDLY: begin
          if (rise | fall) begin
            state_nxt = S_SYNC;
          end else if (cnt == 4'd0) begin
            cap_l     = 1'b1;
            state_nxt = S_WFALL;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        S_WFALL: begin
          if (rise) begin
            state_nxt = S_SYNC;
          end else if (fall) begin
            state_nxt = S_RDLY;
            cnt_nxt   = HOLD;
          end
        end
        S_RDLY: begin
          if (rise | fall) begin
            state_nxt = S_SYNC;
          end else if (cnt == 4'd0) begin
            push      = 1'b1;
            state_nxt = S_WRISE;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        S_WRISE: begin
          if (rise) begin
            state_nxt = S_LDLY;
            cnt_nxt   = HOLD;
          end
        end
        default: state_nxt = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ws0     <= 1'b0;
      ws1     <= 1'b0;
      ws2     <= 1'b0;
      state   <= S_SYNC;
      cnt     <= 4'd0;
      l_hold  <= '0;
      dl_hold <= 1'b0;
    end else begin
      ws0   <= i2s_wclk;
      ws1   <= ws0;
      ws2   <= ws1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (cap_l) begin
        l_hold  <= dataL;
        dl_hold <= detectL;
      end
    end
  end

  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W:0] wp, rp, wp_nxt, rp_nxt;
  logic empty, full, pop, wr, drop;
  logic [FW-1:0] head;

  assign empty = (wp == rp);
  assign full  = (wp[ADDR_W] != rp[ADDR_W]) &&
                 (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]);
  assign pop   = ~empty & frame_ready;
  assign wr    = push & (~full | pop);
  assign drop  = push & full & ~pop;

  assign wp_nxt = wp + {{ADDR_W{1'b0}}, wr};
  assign rp_nxt = rp + {{ADDR_W{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (wr) mem[wp[ADDR_W-1:0]] <= {l_hold, dataR, dl_hold, detectR};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      wp         <= wp_nxt;
      rp         <= rp_nxt;
      fifo_level <= wp_nxt - rp_nxt;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // Head is gated so outputs read 0 while empty, including after reset.
  assign head         = mem[rp[ADDR_W-1:0]];
  assign frame_valid  = ~empty;
  assign frame_data   = frame_valid ? head[FW-1:2] : '0;
  assign frame_detect = frame_valid ? head[1:0] : 2'b00;

endmodule
